// File: rtl/eth_tx_pktgen.sv
// -----------------------------------------------------------------------------
// eth_tx_pktgen -- Ethernet TX test-packet generator (Eth_Clk domain).
//
// Generates runs of payload packets on the eth_tx byte-stream interface. The
// packet length, payload pattern, inter-packet gap and packets-per-run are
// captured when a run starts and held until it ends.
//
// Ports
//   Clk            Eth_Clk domain clock
//   Rst            synchronous, active-high reset
//   Test_En        asynchronous level; rising edge starts a run, low stops it
//   Cfg_Len        payload bytes per packet (0 -> 1, clamped to MAX_LEN)
//   Cfg_Mode       0 increment, 1 constant, 2 LFSR, 3 walking-one
//   Cfg_Seed       start value (increment/LFSR) or constant byte
//   Cfg_Gap        idle cycles between Eth_Pkt_Rdy and the next first byte
//   Cfg_Pkt_Cnt    packets per run, 0 = continuous
//   Eth_Byte       payload byte, 0x00 when not valid
//   Eth_Byte_Valid payload byte valid
//   Eth_Pkt_Rdy    one-cycle pulse after the last byte of a packet
//   Busy           FSM is neither IDLE nor DONE
//   Done           FSM is in DONE
//   Pkt_Sent_Cnt   packets completed in the current run, saturating
// -----------------------------------------------------------------------------
module eth_tx_pktgen #(
  parameter int MAX_LEN     = 1500,
  parameter int LEN_W       = 11,
  parameter int GAP_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Test_En,
  input  logic [LEN_W-1:0] Cfg_Len,
  input  logic [1:0]       Cfg_Mode,
  input  logic [7:0]       Cfg_Seed,
  input  logic [GAP_W-1:0] Cfg_Gap,
  input  logic [CNT_W-1:0] Cfg_Pkt_Cnt,
  output logic [7:0]       Eth_Byte,
  output logic             Eth_Byte_Valid,
  output logic             Eth_Pkt_Rdy,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Pkt_Sent_Cnt
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_RDY, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {MODE_INC, MODE_CONST, MODE_LFSR, MODE_WALK} mode_e;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  // First byte of every packet for a given pattern.
  function automatic logic [7:0] first_byte(input mode_e mode, input logic [7:0] seed);
    logic [7:0] b;
    case (mode)
      MODE_INC, MODE_CONST: b = seed;
      MODE_LFSR:            b = (seed == 8'h00) ? 8'h01 : seed; // all-zero would lock up
      default:              b = 8'h01;
    endcase
    return b;
  endfunction

  // Byte following b within a packet.
  function automatic logic [7:0] next_byte(input mode_e mode, input logic [7:0] b);
    logic [7:0] n;
    case (mode)
      MODE_INC:   n = b + 8'd1;
      MODE_CONST: n = b;
      MODE_LFSR:  n = {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]}; // x^8+x^6+x^5+x^4+1
      default:    n = {b[6:0], b[7]};
    endcase
    return n;
  endfunction

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [LEN_W-1:0]       len_q, len_d;
  mode_e                  mode_q, mode_d;
  logic [7:0]             seed_q, seed_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]       sent_q, sent_d;
  logic [LEN_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [7:0]             pat_q, pat_d;

  logic             en_sync;
  logic             en_rise;
  logic [LEN_W-1:0] len_clamped;
  logic [CNT_W-1:0] sent_inc;
  mode_e            cfg_mode;

  assign en_sync     = sync_q[SYNC_STAGES-1];
  assign en_rise     = en_sync & ~prev_q;
  assign cfg_mode    = mode_e'(Cfg_Mode);
  assign len_clamped = (Cfg_Len == '0)       ? LEN_W'(1)  :
                       (Cfg_Len > MAX_LEN_L) ? MAX_LEN_L  : Cfg_Len;
  assign sent_inc    = (sent_q == '1) ? sent_q : sent_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    len_d      = len_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    gap_d      = gap_q;
    pkt_cnt_d  = pkt_cnt_q;
    sent_d     = sent_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pat_d      = pat_q;

    case (state_q)
      S_IDLE: begin
        if (en_rise) begin
          len_d      = len_clamped;
          mode_d     = cfg_mode;
          seed_d     = Cfg_Seed;
          gap_d      = Cfg_Gap;
          pkt_cnt_d  = Cfg_Pkt_Cnt;
          sent_d     = '0;
          byte_cnt_d = '0;
          pat_d      = first_byte(cfg_mode, Cfg_Seed);
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        pat_d      = next_byte(mode_q, pat_q);
        byte_cnt_d = byte_cnt_q + LEN_W'(1);
        // A falling Test_En is deliberately ignored here: packets never truncate.
        if (byte_cnt_q == len_q - LEN_W'(1)) state_d = S_RDY;
      end
      S_RDY: begin
        sent_d     = sent_inc;
        byte_cnt_d = '0;
        gap_cnt_d  = '0;
        pat_d      = first_byte(mode_q, seed_q);
        if (pkt_cnt_q != '0 && sent_inc == pkt_cnt_q) state_d = S_DONE;
        else if (!en_sync)                             state_d = S_IDLE;
        else if (gap_q != '0)                          state_d = S_GAP;
        else                                           state_d = S_SEND;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == gap_q - GAP_W'(1)) state_d = en_sync ? S_SEND : S_IDLE;
      end
      S_DONE: begin
        // Leaving only on a low level forces a fresh rising edge for a new run.
        if (!en_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      len_q      <= '0;
      mode_q     <= MODE_INC;
      seed_q     <= '0;
      gap_q      <= '0;
      pkt_cnt_q  <= '0;
      sent_q     <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      pat_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], Test_En};
      prev_q     <= en_sync;
      len_q      <= len_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      gap_q      <= gap_d;
      pkt_cnt_q  <= pkt_cnt_d;
      sent_q     <= sent_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pat_q      <= pat_d;
    end
  end

  // Outputs decode directly from state, so a reset clears them on the next cycle.
  assign Eth_Byte_Valid = (state_q == S_SEND);
  assign Eth_Byte       = Eth_Byte_Valid ? pat_q : 8'h00;
  assign Eth_Pkt_Rdy    = (state_q == S_RDY);
  assign Busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign Done           = (state_q == S_DONE);
  assign Pkt_Sent_Cnt   = sent_q;

endmodule

// File: doc/eth_tx_pktgen.md
Name: eth_tx_pktgen

Overview:
Parametrised Ethernet TX test-packet generator in the Eth_Clk domain. It drives the byte-stream interface of eth_tx: Eth_Byte, Eth_Byte_Valid, and a one-cycle Eth_Pkt_Rdy after each packet. It adds the following, all latched per run:
- configurable packet length
- selectable payload patterns
- multi-packet runs with an inter-packet gap
- a sent-packet counter

Parameters:
MAX_LEN, 1500, largest payload length in bytes; longer requests are clamped to it.
LEN_W, 11, width of Cfg_Len and of the internal byte counter; must hold MAX_LEN.
GAP_W, 16, width of Cfg_Gap.
CNT_W, 16, width of Cfg_Pkt_Cnt and Pkt_Sent_Cnt.
SYNC_STAGES, 2, number of synchroniser flops on Test_En; minimum 2.

Ports:
Clk  in  1  Eth_Clk domain clock.
Rst  in  1  synchronous, active-high reset.
Test_En  in  1  asynchronous level; a rising edge starts a run, low requests a stop.
Cfg_Len  in  LEN_W  payload bytes per packet.
Cfg_Mode  in  2  pattern select: 0 = increment, 1 = constant, 2 = LFSR, 3 = walking-one.
Cfg_Seed  in  8  start value for increment and LFSR modes; the byte value in constant mode.
Cfg_Gap  in  GAP_W  idle cycles between a packet's Eth_Pkt_Rdy and the next packet's first byte.
Cfg_Pkt_Cnt  in  CNT_W  packets per run; 0 = continuous.
Eth_Byte  out  8  payload byte.
Eth_Byte_Valid  out  1  Eth_Byte is valid this cycle.
Eth_Pkt_Rdy  out  1  one-cycle pulse after a packet's last byte.
Busy  out  1  high whenever the FSM is not in IDLE or DONE.
Done  out  1  high in DONE.
Pkt_Sent_Cnt  out  CNT_W  packets completed in the current run; saturates.

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, synchroniser flops are 0, latched config is 0.
- Test_En passes through SYNC_STAGES flops plus one edge-detect flop. Rise = sync & ~prev.
- FSM states: IDLE, SEND, RDY, GAP, DONE.
- IDLE, on rise:
  - latch Cfg_*; Cfg_Len is clamped to [1, MAX_LEN] (0 becomes 1);
  - clear Pkt_Sent_Cnt;
  - go to SEND.
  - With SYNC_STAGES=2, Eth_Byte_Valid is first high after the 3rd rising edge that samples Test_En high.
- SEND:
  - Eth_Byte_Valid = 1 for exactly Len consecutive cycles, with no bubbles.
  - After the last byte, go to RDY.
- RDY:
  - exactly one cycle with Eth_Pkt_Rdy = 1 and Eth_Byte_Valid = 0;
  - Pkt_Sent_Cnt increments, saturating at all-ones.
  - Next state, in priority order:
    1. DONE if Pkt_Cnt != 0 and the post-increment count == Pkt_Cnt;
    2. IDLE if synced Test_En = 0;
    3. GAP if Gap != 0;
    4. SEND otherwise (back-to-back packets).
- GAP: outputs idle for exactly Gap cycles. Then go to SEND, or to IDLE if synced Test_En = 0 at the end of the gap.
- DONE: Done = 1. Go to IDLE when synced Test_En = 0. A new run needs a fresh rising edge.
- Test_En dropping mid-SEND: the current packet is never truncated. It completes, pulses Eth_Pkt_Rdy, then the FSM goes to IDLE.
- Test_En rising while not in IDLE: ignored.
- Patterns restart at the start of every packet:
  - Mode 0 (increment): byte0 = Seed, then +1 per byte, wrapping 0xFF -> 0x00.
  - Mode 1 (constant): every byte = Seed.
  - Mode 2 (LFSR): byte0 = Seed, or 0x01 if Seed = 0. Next value = {b[6:0], b[7]^b[5]^b[4]^b[3]} (Fibonacci LFSR, x^8+x^6+x^5+x^4+1).
  - Mode 3 (walking-one): byte0 = 0x01, then rotate left by 1 each byte; Seed is ignored.
- Eth_Byte holds 0x00 whenever Eth_Byte_Valid = 0.
- Latched config is not changed by Cfg_* changes mid-run.
- Rst asserted mid-operation: next cycle all outputs are 0 and the FSM is in IDLE. No Eth_Pkt_Rdy is emitted for the partial packet.

Test Plan:
1. Mode 0, Seed=1, Len=100, Pkt_Cnt=1, Gap=0, pulse Test_En high -> bytes 1..100 on 100 consecutive valid cycles; Eth_Pkt_Rdy on the next cycle; Pkt_Sent_Cnt=1; Done=1; Busy=0.
2. Mode 1, Seed=0xA5, Len=3, Pkt_Cnt=4, Gap=5 -> four packets of A5 A5 A5; exactly 5 idle cycles between each Eth_Pkt_Rdy and the next valid byte; Pkt_Sent_Cnt counts 1..4 and ends at 4.
3. Mode 0, Seed=0xFE, Len=4, then Mode 2, Seed=0, Len=4 -> FE FF 00 01, then 01 02 04 08; Len=0 yields one byte; Len=2000 yields 1500 bytes.
4. Mode 3, Len=10, Pkt_Cnt=0, drop Test_En at byte 4 of packet 3 -> packet 3 completes (01 02 04 08 10 20 40 80 01 02) with Eth_Pkt_Rdy; then IDLE; Pkt_Sent_Cnt=3; Done=0.
5. Assert Rst during byte 50 of a 100-byte packet -> next cycle Eth_Byte_Valid=0, Eth_Pkt_Rdy=0, Pkt_Sent_Cnt=0; no pulse emitted; a new Test_En rise restarts from byte0.
6. Change Cfg_Len and Cfg_Mode mid-run, and toggle Test_En during DONE -> packets keep the latched config; no restart until Test_En falls and rises again.
